// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped L1 cache.
package cache_pkg;

  // Line fields are carried at this fixed width; the storage keeps only the bits it needs.
  localparam int CACHE_FIELD_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_t;

  typedef struct packed {
    logic                     valid;
    logic [CACHE_FIELD_W-1:0] tag;
    logic [CACHE_FIELD_W-1:0] data;
  } cache_line_t;

  function automatic logic [CACHE_FIELD_W-1:0] get_index(input logic [CACHE_FIELD_W-1:0] addr,
                                                         input int                       index_w);
    return (addr >> 2) & ((CACHE_FIELD_W'(1) << index_w) - CACHE_FIELD_W'(1));
  endfunction

  function automatic logic [CACHE_FIELD_W-1:0] get_tag(input logic [CACHE_FIELD_W-1:0] addr,
                                                       input int                       index_w);
    return addr >> (index_w + 2);
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// LINES-entry valid/tag/data storage: combinational read by index, one synchronous
// write port, valid bits cleared by synchronous reset.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 26,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index_i,
  output cache_line_t        rd_line_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  cache_line_t        wr_line_i
);

  logic [LINES-1:0]             valid_vec;
  logic [LINES-1:0][TAG_W-1:0]  tag_vec;
  logic [LINES-1:0][DATA_W-1:0] data_vec;
  logic                         unused_wr_bits;

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic              valid_q;
      logic [TAG_W-1:0]  tag_q;
      logic [DATA_W-1:0] data_q;
      logic              wr_sel;

      assign wr_sel = wr_en_i && (wr_index_i == INDEX_W'(gi));

      // Tag and data need no reset: they are only trusted while valid_q is set.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (wr_sel) begin
          valid_q <= wr_line_i.valid;
          tag_q   <= wr_line_i.tag[TAG_W-1:0];
          data_q  <= wr_line_i.data[DATA_W-1:0];
        end
      end

      assign valid_vec[gi] = valid_q;
      assign tag_vec[gi]   = tag_q;
      assign data_vec[gi]  = data_q;
    end
  endgenerate

  always_comb begin
    rd_line_o       = '0;
    rd_line_o.valid = valid_vec[rd_index_i];
    rd_line_o.tag   = CACHE_FIELD_W'(tag_vec[rd_index_i]);
    rd_line_o.data  = CACHE_FIELD_W'(data_vec[rd_index_i]);
  end

  assign unused_wr_bits = ^{wr_line_i.tag[CACHE_FIELD_W-1:TAG_W],
                            wr_line_i.data[CACHE_FIELD_W-1:DATA_W]};

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 cache driving one mem_if port.
// Define L1_CACHE_PERF_EN to add the hit_count/miss_count read-access counters.
module l1_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LINES       = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] mem_data_o,
  output logic              mem_data_en,
  output logic              mem_write_en
`ifdef L1_CACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;
  localparam int CNT_W   = $clog2(MEM_LATENCY + 1);

  cache_state_t       state_q;
  logic               req_ready_q;
  logic               resp_valid_q;
  logic [DATA_W-1:0]  resp_rdata_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_data_i_q;
  logic               mem_data_en_q;
  logic               mem_write_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               wr_hit_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [CACHE_FIELD_W-1:0] req_addr_x;
  logic [CACHE_FIELD_W-1:0] req_index_x;
  logic [CACHE_FIELD_W-1:0] req_tag_x;
  logic [CACHE_FIELD_W-1:0] lat_addr_x;
  logic [CACHE_FIELD_W-1:0] lat_index_x;
  logic [CACHE_FIELD_W-1:0] lat_tag_x;

  cache_line_t        rd_line;
  cache_line_t        wr_line;
  logic               wr_en;
  logic               hit;
  logic               accept;
  logic               unused_bits;

  assign req_addr_x  = CACHE_FIELD_W'(req_addr);
  assign req_index_x = get_index(req_addr_x, INDEX_W);
  assign req_tag_x   = get_tag(req_addr_x, INDEX_W);
  assign lat_addr_x  = CACHE_FIELD_W'(addr_q);
  assign lat_index_x = get_index(lat_addr_x, INDEX_W);
  assign lat_tag_x   = get_tag(lat_addr_x, INDEX_W);

  // Tags compare at full field width; the zero-extended upper bits match trivially.
  assign hit    = rd_line.valid && (rd_line.tag == req_tag_x);
  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

  // Fill captures on the last counted FILL cycle; a store only touches the line it hit.
  assign wr_en = ((state_q == FILL) && (cnt_q == '0)) || ((state_q == WRITE) && wr_hit_q);

  always_comb begin
    wr_line       = '0;
    wr_line.valid = 1'b1;
    wr_line.tag   = lat_tag_x;
    wr_line.data  = (state_q == FILL) ? CACHE_FIELD_W'(mem_data_o) : CACHE_FIELD_W'(wdata_q);
  end

  cache_tag_store #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (req_index_x[INDEX_W-1:0]),
    .rd_line_o  (rd_line),
    .wr_en_i    (wr_en),
    .wr_index_i (lat_index_x[INDEX_W-1:0]),
    .wr_line_i  (wr_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      mem_addr_q     <= '0;
      mem_data_i_q   <= '0;
      mem_data_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wr_hit_q       <= 1'b0;
      cnt_q          <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_data_en_q  <= 1'b0;
          mem_write_en_q <= 1'b0;
          if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wr_hit_q <= hit;
            if (req_write) begin
              state_q        <= WRITE;
              req_ready_q    <= 1'b0;
              mem_addr_q     <= req_addr;
              mem_data_i_q   <= req_wdata;
              mem_data_en_q  <= 1'b1;
              mem_write_en_q <= 1'b1;
            end else if (hit) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= rd_line.data[DATA_W-1:0];
            end else begin
              state_q       <= FILL;
              req_ready_q   <= 1'b0;
              mem_addr_q    <= req_addr;
              mem_data_en_q <= 1'b1;
              cnt_q         <= CNT_W'(MEM_LATENCY);
            end
          end
        end
        FILL: begin
          mem_data_en_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= mem_data_o;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WRITE: begin
          mem_data_en_q  <= 1'b0;
          mem_write_en_q <= 1'b0;
          state_q        <= IDLE;
          req_ready_q    <= 1'b1;
          resp_valid_q   <= 1'b1;
          resp_rdata_q   <= '0;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef L1_CACHE_PERF_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (accept && !req_write) begin
      if (hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end else begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_i   = mem_data_i_q;
  assign mem_data_en  = mem_data_en_q;
  assign mem_write_en = mem_write_en_q;

  assign unused_bits = ^{req_index_x[CACHE_FIELD_W-1:INDEX_W],
                         lat_index_x[CACHE_FIELD_W-1:INDEX_W],
                         rd_line.data[CACHE_FIELD_W-1:DATA_W]};

endmodule

// File: tb/tb_l1_cache.sv
// Scoreboard bench for l1_cache with a one-cycle-latency memory responder model.
module tb_l1_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_data_en;
  logic        mem_write_en;
`ifdef L1_CACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  l1_cache #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .LINES       (16),
    .MEM_LATENCY (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o),
    .mem_data_en  (mem_data_en),
    .mem_write_en (mem_write_en)
`ifdef L1_CACHE_PERF_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  logic [31:0] last_mem_addr = '0;
  logic [31:0] last_mem_wdata = '0;
  logic        last_mem_we = 1'b0;
  logic [31:0] mem_model [0:1023];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: data_o valid the cycle after a read data_en.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_model[i] <= 32'h1000_0000 | 32'(i);
      mem_model[16] <= 32'hDEAD_BEEF;
    end else if (mem_data_en) begin
      if (mem_write_en) mem_model[mem_addr[11:2]] <= mem_data_i;
      else              mem_data_o <= mem_model[mem_addr[11:2]];
    end
  end

  always @(negedge clk) begin
    if (mem_data_en) begin
      en_cnt         <= en_cnt + 1;
      last_mem_addr  <= mem_addr;
      last_mem_wdata <= mem_data_i;
      last_mem_we    <= mem_write_en;
    end
    if (mem_write_en) check("we_without_en", mem_data_en, 1);
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", resp_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_data", resp_rdata, mon_e.data);
        check("resp_cycle", cyc, mon_e.cyc);
        $display("RESP cyc=%0d data=%08h exp=%08h", cyc, resp_rdata, mon_e.data);
      end
    end
  end

  // d = response offset from the accept edge: 0 hit, 1 store, 2 miss (MEM_LATENCY = 1).
  task automatic issue(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input int d, input bit push);
    bit rdy;
    int guard = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = addr;
    req_wdata = wdata;
    do begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 100);
    req_valid = 1'b0;
    check("accept", rdy, 1);
    if (rdy && push) begin
      sb_q.push_back('{data: exp_data, cyc: cyc + d});
      if (!w) begin
        if (d == 0) exp_hits++;
        else        exp_misses++;
      end
      $display("REQ  cyc=%0d %s addr=%08h wdata=%08h", cyc, w ? "ST" : "LD", addr, wdata);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    int en_snap;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_en", mem_data_en, 0);
    check("rst_mem_we", mem_write_en, 0);
    check("rst_mem_addr", mem_addr, 0);
`ifdef L1_CACHE_PERF_EN
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
`endif

    // Cold miss then hits (including ignored low address bits).
    en_snap = en_cnt;
    issue(1'b0, 32'h40, '0, 32'hDEAD_BEEF, 2, 1'b1);
    drain();
    check("miss_en_pulses", en_cnt - en_snap, 1);
    check("miss_mem_addr", last_mem_addr, 32'h40);
    check("miss_mem_we", last_mem_we, 0);
    en_snap = en_cnt;
    issue(1'b0, 32'h40, '0, 32'hDEAD_BEEF, 0, 1'b1);
    for (int k = 0; k < 4; k++) issue(1'b0, 32'h40 | 32'(k), '0, 32'hDEAD_BEEF, 0, 1'b1);
    drain();
    check("hit_en_pulses", en_cnt - en_snap, 0);

    // Store hit: written through, line updated.
    issue(1'b1, 32'h40, 32'h1234_5678, 32'h0, 1, 1'b1);
    drain();
    check("st_mem_addr", last_mem_addr, 32'h40);
    check("st_mem_we", last_mem_we, 1);
    check("st_mem_wdata", last_mem_wdata, 32'h1234_5678);
    en_snap = en_cnt;
    issue(1'b0, 32'h40, '0, 32'h1234_5678, 0, 1'b1);
    drain();
    check("st_hit_en_pulses", en_cnt - en_snap, 0);

    // Store miss: no allocate, line 0 still holds 0x40.
    issue(1'b1, 32'h80, 32'hAAAA_5555, 32'h0, 1, 1'b1);
    issue(1'b0, 32'h40, '0, 32'h1234_5678, 0, 1'b1);
    issue(1'b0, 32'h80, '0, 32'hAAAA_5555, 2, 1'b1);
    drain();

    // Conflict on index 0.
    issue(1'b0, 32'h40, '0, 32'h1234_5678, 2, 1'b1);
    issue(1'b0, 32'h440, '0, 32'h1000_0110, 2, 1'b1);
    issue(1'b0, 32'h40, '0, 32'h1234_5678, 2, 1'b1);
    drain();

    // Other indices: miss then hit.
    for (int k = 1; k < 4; k++) begin
      issue(1'b0, 32'h200 + 32'(4 * k), '0, 32'h1000_0080 + 32'(k), 2, 1'b1);
      issue(1'b0, 32'h200 + 32'(4 * k), '0, 32'h1000_0080 + 32'(k), 0, 1'b1);
    end
    drain();
`ifdef L1_CACHE_PERF_EN
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
`endif

    // Reset during FILL abandons the fill.
    issue(1'b0, 32'h100, '0, 32'h0, 2, 1'b0);
    check("fill_mem_en", mem_data_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_ready", req_ready, 1);
`ifdef L1_CACHE_PERF_EN
    check("post_rst_hit_count", hit_count, 0);
    check("post_rst_miss_count", miss_count, 0);
`endif
    en_snap = en_cnt;
    issue(1'b0, 32'h100, '0, 32'h1000_0040, 2, 1'b1);
    drain();
    check("post_rst_refill", en_cnt - en_snap, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
